// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU opcodes, forwarding select codes, multiplier FSM states.
package pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_MUL  = 4'd12;

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ctrl_t;

endpackage

// File: rtl/ex_stage_mul.sv
// Iterative shift-add multiplier: latches operands on start, one step per cycle while busy.
module mul_iter
  import pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MUL_ITERS = 32,
  parameter int CW        = $clog2(MUL_ITERS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            busy,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  logic [XLEN-1:0] mcand, mplier, acc;
  logic [CW-1:0]   count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (start) begin
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
      count  <= '0;
    end else if (busy) begin
      // only the low XLEN bits of the product are kept, so the multiplicand simply shifts out
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

  assign done    = busy && (count == CW'(MUL_ITERS - 1));
  assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, iterative multiply and the EX/MEM pipeline register.
module ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MUL_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic            id_ex_valid,
  input  logic [XLEN-1:0] id_ex_rs_data,
  input  logic [XLEN-1:0] id_ex_rt_data,
  input  logic [XLEN-1:0] id_ex_imm,
  input  logic            id_ex_alusrc,
  input  logic [3:0]      id_ex_aluop,
  input  logic [4:0]      id_ex_write_addr,
  input  logic            id_ex_regwrite,
  input  logic            id_ex_memread,
  input  logic            id_ex_memwrite,
  input  logic            id_ex_memtoreg,
  input  logic [XLEN-1:0] mem_wb_write_data,
  input  logic            mem_stall,
  input  logic            flush,
  output logic            stall_out,
  output logic            ex_mem_valid,
  output logic [XLEN-1:0] ex_mem_alu_result,
  output logic [XLEN-1:0] ex_mem_store_data,
  output logic [4:0]      ex_mem_write_addr,
  output logic            ex_mem_regwrite,
  output logic            ex_mem_memread,
  output logic            ex_mem_memwrite,
  output logic            ex_mem_memtoreg
);

  logic [XLEN-1:0] opa, opb_fwd, opb, alu_res, mul_prod;
  logic [4:0]      shamt;
  logic            is_mul, mul_start, mul_done, stall;
  mul_state_e      state, state_nx;
  ctrl_t           id_ctrl, nx_ctrl;
  logic            nx_valid, ld;
  logic [XLEN-1:0] nx_result, nx_store;
  logic [4:0]      nx_addr;

  assign id_ctrl = '{regwrite: id_ex_regwrite, memread: id_ex_memread,
                     memwrite: id_ex_memwrite, memtoreg: id_ex_memtoreg};

  always_comb begin
    case (forward_a)
      FWD_EXMEM: opa = ex_mem_alu_result;
      FWD_MEMWB: opa = mem_wb_write_data;
      default:   opa = id_ex_rs_data;
    endcase
    case (forward_b)
      FWD_EXMEM: opb_fwd = ex_mem_alu_result;
      FWD_MEMWB: opb_fwd = mem_wb_write_data;
      default:   opb_fwd = id_ex_rt_data;
    endcase
  end

  assign opb   = id_ex_alusrc ? id_ex_imm : opb_fwd;
  assign shamt = opb[4:0];

  // MUL is produced by the multiplier, so the ALU treats its code like any unused one
  always_comb begin
    alu_res = '0;
    case (id_ex_aluop)
      ALU_ADD:  alu_res = opa + opb;
      ALU_SUB:  alu_res = opa - opb;
      ALU_AND:  alu_res = opa & opb;
      ALU_OR:   alu_res = opa | opb;
      ALU_XOR:  alu_res = opa ^ opb;
      ALU_NOR:  alu_res = ~(opa | opb);
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, opa < opb};
      ALU_SLL:  alu_res = opa << shamt;
      ALU_SRL:  alu_res = opa >> shamt;
      ALU_SRA:  alu_res = $signed(opa) >>> shamt;
      default:  alu_res = '0;
    endcase
  end

  assign is_mul = id_ex_valid && (id_ex_aluop == ALU_MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    stall     = 1'b0;
    mul_start = 1'b0;
    case (state)
      IDLE: begin
        stall = mem_stall || (is_mul && !flush);
        if (is_mul && !mem_stall && !flush) begin
          mul_start = 1'b1;
          state_nx  = RUN;
        end
      end
      RUN: begin
        stall = 1'b1;
        if (mul_done) state_nx = DONE;
      end
      DONE: begin
        stall = mem_stall;
        if (!mem_stall) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // held low through reset even if ID/EX still presents a MUL
  assign stall_out = rst_n && stall;

  mul_iter #(.XLEN(XLEN), .MUL_ITERS(MUL_ITERS)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .busy    (state == RUN),
    .op_a    (opa),
    .op_b    (opb),
    .done    (mul_done),
    .product (mul_prod)
  );

  // next EX/MEM contents; default is a bubble
  always_comb begin
    ld        = flush || !mem_stall;
    nx_valid  = 1'b0;
    nx_ctrl   = '0;
    nx_result = '0;
    nx_store  = '0;
    nx_addr   = '0;
    if (!flush) begin
      case (state)
        IDLE: if (!mul_start) begin
          nx_valid  = id_ex_valid;
          nx_ctrl   = id_ctrl;
          nx_result = alu_res;
          nx_store  = opb_fwd;
          nx_addr   = id_ex_write_addr;
        end
        DONE: begin
          nx_valid  = id_ex_valid;
          nx_ctrl   = id_ctrl;
          nx_result = mul_prod;
          nx_store  = opb_fwd;
          nx_addr   = id_ex_write_addr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_valid      <= 1'b0;
      ex_mem_alu_result <= '0;
      ex_mem_store_data <= '0;
      ex_mem_write_addr <= '0;
      ex_mem_regwrite   <= 1'b0;
      ex_mem_memread    <= 1'b0;
      ex_mem_memwrite   <= 1'b0;
      ex_mem_memtoreg   <= 1'b0;
    end else if (ld) begin
      ex_mem_valid      <= nx_valid;
      ex_mem_alu_result <= nx_result;
      ex_mem_store_data <= nx_store;
      ex_mem_write_addr <= nx_addr;
      ex_mem_regwrite   <= nx_ctrl.regwrite;
      ex_mem_memread    <= nx_ctrl.memread;
      ex_mem_memwrite   <= nx_ctrl.memwrite;
      ex_mem_memtoreg   <= nx_ctrl.memtoreg;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU corners, mem_stall hold, multiply timing, flush and reset.
module tb_ex_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  forward_a, forward_b;
  logic        id_ex_valid, id_ex_alusrc;
  logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm, mem_wb_write_data;
  logic [3:0]  id_ex_aluop;
  logic [4:0]  id_ex_write_addr;
  logic        id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg;
  logic        mem_stall, flush;
  logic        stall_out, ex_mem_valid;
  logic [31:0] ex_mem_alu_result, ex_mem_store_data;
  logic [4:0]  ex_mem_write_addr;
  logic        ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite, ex_mem_memtoreg;

  int errors = 0;
  int checks = 0;
  int stall_cnt;
  int valid_seen;

  ex_stage #(.XLEN(32), .MUL_ITERS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .forward_a(forward_a), .forward_b(forward_b),
    .id_ex_valid(id_ex_valid), .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
    .id_ex_imm(id_ex_imm), .id_ex_alusrc(id_ex_alusrc), .id_ex_aluop(id_ex_aluop),
    .id_ex_write_addr(id_ex_write_addr), .id_ex_regwrite(id_ex_regwrite),
    .id_ex_memread(id_ex_memread), .id_ex_memwrite(id_ex_memwrite), .id_ex_memtoreg(id_ex_memtoreg),
    .mem_wb_write_data(mem_wb_write_data), .mem_stall(mem_stall), .flush(flush),
    .stall_out(stall_out), .ex_mem_valid(ex_mem_valid), .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_store_data(ex_mem_store_data), .ex_mem_write_addr(ex_mem_write_addr),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memread(ex_mem_memread),
    .ex_mem_memwrite(ex_mem_memwrite), .ex_mem_memtoreg(ex_mem_memtoreg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [4:0] wa);
    id_ex_valid      = 1'b1;
    id_ex_aluop      = op;
    id_ex_rs_data    = rs;
    id_ex_rt_data    = rt;
    id_ex_write_addr = wa;
    id_ex_regwrite   = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; forward_a = FWD_IDEX; forward_b = FWD_IDEX;
    id_ex_valid = 0; id_ex_rs_data = 0; id_ex_rt_data = 0; id_ex_imm = 0;
    id_ex_alusrc = 0; id_ex_aluop = ALU_ADD; id_ex_write_addr = 0;
    id_ex_regwrite = 0; id_ex_memread = 0; id_ex_memwrite = 0; id_ex_memtoreg = 0;
    mem_wb_write_data = 0; mem_stall = 0; flush = 0;
    #3;
    check("rst_valid", ex_mem_valid, 0);
    check("rst_result", ex_mem_alu_result, 0);
    check("rst_stall", stall_out, 0);
    #9 rst_n = 1'b1;

    // forwarding: EX/MEM=5 into A, MEM/WB=7 into B
    set_op(ALU_ADD, 32'd5, 32'd0, 5'd3);
    step();
    check("add_seed", ex_mem_alu_result, 32'd5);
    forward_a = FWD_EXMEM; forward_b = FWD_MEMWB; mem_wb_write_data = 32'd7;
    id_ex_rs_data = 32'd100; id_ex_rt_data = 32'd200;
    step();
    check("fwd_add", ex_mem_alu_result, 32'd12);
    check("fwd_valid", ex_mem_valid, 1);
    check("fwd_store", ex_mem_store_data, 32'd7);
    check("fwd_waddr", ex_mem_write_addr, 5'd3);
    check("fwd_regwrite", ex_mem_regwrite, 1);
    forward_a = FWD_IDEX; forward_b = FWD_IDEX;

    set_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd4);
    step();
    check("slt", ex_mem_alu_result, 32'd1);
    id_ex_aluop = ALU_SLTU;
    step();
    check("sltu", ex_mem_alu_result, 32'd0);
    set_op(ALU_SRA, 32'h8000_0000, 32'h1234_5678, 5'd5);
    id_ex_alusrc = 1'b1; id_ex_imm = 32'd4;
    step();
    check("sra", ex_mem_alu_result, 32'hF800_0000);
    check("sra_store_pre_alusrc", ex_mem_store_data, 32'h1234_5678);
    id_ex_aluop = ALU_SRL;
    step();
    check("srl", ex_mem_alu_result, 32'h0800_0000);
    id_ex_alusrc = 1'b0;
    set_op(ALU_SUB, 32'd3, 32'd5, 5'd6);
    step();
    check("sub_wrap", ex_mem_alu_result, 32'hFFFF_FFFE);
    set_op(4'd11, 32'd3, 32'd5, 5'd6);
    step();
    check("unused_op", ex_mem_alu_result, 32'd0);

    // mem_stall hold
    set_op(ALU_ADD, 32'd1, 32'd1, 5'd7);
    step();
    check("pre_stall", ex_mem_alu_result, 32'd2);
    set_op(ALU_XOR, 32'hF0, 32'h0F, 5'd8);
    mem_stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("memstall_stall", stall_out, 1);
      step();
      check("memstall_hold", ex_mem_alu_result, 32'd2);
      check("memstall_addr", ex_mem_write_addr, 5'd7);
    end
    mem_stall = 1'b0;
    step();
    check("memstall_release", ex_mem_alu_result, 32'hFF);
    check("memstall_rel_addr", ex_mem_write_addr, 5'd8);

    // MUL: sources change after the start cycle and must be ignored
    set_op(ALU_MUL, 32'h1234_5678, 32'h10, 5'd9);
    #1;
    stall_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (!stall_out) break;
      stall_cnt++;
      @(posedge clk); #1;
      if (c == 0) begin
        forward_a = FWD_MEMWB; mem_wb_write_data = 32'hDEAD_BEEF;
        id_ex_rs_data = 32'd0; id_ex_rt_data = 32'hFFFF;
      end
      #1;
    end
    check("mul_stall_cycles", stall_cnt, 33);
    check("mul_bubble_while_run", ex_mem_valid, 0);
    step();
    check("mul_result", ex_mem_alu_result, 32'h2345_6780);
    check("mul_valid", ex_mem_valid, 1);
    check("mul_waddr", ex_mem_write_addr, 5'd9);
    id_ex_valid = 1'b0; id_ex_regwrite = 1'b0; forward_a = FWD_IDEX;
    #1;
    check("mul_after_stall", stall_out, 0);

    // flush at RUN cycle 10
    set_op(ALU_MUL, 32'd3, 32'd4, 5'd10);
    #1;
    check("flushmul_start_stall", stall_out, 1);
    for (int i = 0; i < 11; i++) step();
    check("flushmul_run_stall", stall_out, 1);
    check("flushmul_run_bubble", ex_mem_valid, 0);
    flush = 1'b1; id_ex_valid = 1'b0; id_ex_regwrite = 1'b0;
    step();
    flush = 1'b0;
    check("flush_valid", ex_mem_valid, 0);
    check("flush_regwrite", ex_mem_regwrite, 0);
    check("flush_result", ex_mem_alu_result, 0);
    #1;
    check("flush_stall_next", stall_out, 0);
    valid_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ex_mem_valid || ex_mem_regwrite) valid_seen++;
    end
    check("flush_no_writeback", valid_seen, 0);

    // asynchronous reset mid-MUL
    set_op(ALU_MUL, 32'd5, 32'd6, 5'd11);
    for (int i = 0; i < 5; i++) step();
    check("rstmul_running", stall_out, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_stall", stall_out, 0);
    check("async_rst_valid", ex_mem_valid, 0);
    check("async_rst_result", ex_mem_alu_result, 0);
    check("async_rst_regwrite", ex_mem_regwrite, 0);
    set_op(ALU_ADD, 32'd10, 32'd20, 5'd12);
    step();
    check("rst_held_result", ex_mem_alu_result, 0);
    check("rst_held_addr", ex_mem_write_addr, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_add", ex_mem_alu_result, 32'd30);
    check("post_rst_valid", ex_mem_valid, 1);
    check("post_rst_addr", ex_mem_write_addr, 5'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline: consumes the ForwardA/ForwardB selects produced by the forwarding unit, picks operands, runs the ALU and an iterative multiplier, and registers results into the EX/MEM pipeline register.
- Sits between the ID/EX register and the MEM stage.
- Raises a stall to the front end while a multiply is in flight or MEM holds the pipe.

Parameters:
- XLEN, 32, datapath width.
- MUL_ITERS, 32, multiplier iterations; must equal XLEN.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- forward_a  in  2  operand-A select: 00 ID/EX rs data, 10 EX/MEM result, 01 MEM/WB write data; 11 is treated as 00.
- forward_b  in  2  operand-B select, same encoding, applied before the ALUSrc mux.
- id_ex_valid  in  1  ID/EX holds a real instruction.
- id_ex_rs_data  in  XLEN  rs register value.
- id_ex_rt_data  in  XLEN  rt register value.
- id_ex_imm  in  XLEN  sign-extended immediate.
- id_ex_alusrc  in  1  1 = operand B is imm.
- id_ex_aluop  in  4  ALU opcode from the package.
- id_ex_write_addr  in  5  destination register.
- id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg  in  1 each  control passed through.
- mem_wb_write_data  in  XLEN  WB-stage result, used for forwarding.
- mem_stall  in  1  MEM cannot accept; EX/MEM must hold.
- flush  in  1  kill the instruction in EX.
- stall_out  out  1  hold PC, IF/ID and ID/EX.
- ex_mem_valid  out  1  valid bit of the EX/MEM register.
- ex_mem_alu_result  out  XLEN  registered result; also the internal 10 forwarding source.
- ex_mem_store_data  out  XLEN  forwarded rt value, taken before the ALUSrc mux.
- ex_mem_write_addr  out  5  destination register.
- ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite, ex_mem_memtoreg  out  1 each  registered control.

Behaviour:
- Reset (async, rst_n=0): every output register is 0, multiplier FSM is IDLE, count is 0, and stall_out is 0.
- Operands: opA = mux(forward_a). opB_fwd = mux(forward_b). opB = id_ex_alusrc ? id_ex_imm : opB_fwd.
- ALU ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 12 MUL. Every other code produces 0.
- Shifts shift opA by opB[4:0]. Add, sub and mul wrap modulo 2^XLEN; there is no overflow trap. MUL returns the low XLEN bits.
- Single-cycle ops: latency 1. On a clock edge with mem_stall=0, EX/MEM loads the result, the control bits and ex_mem_valid=id_ex_valid.
- Priority at each edge: rst_n, then flush, then mem_stall, then normal load.
- flush: EX/MEM loads a bubble (valid=0, all four control bits 0, data 0), and the FSM is forced to IDLE.
- mem_stall=1: EX/MEM holds its contents and stall_out=1.
- FSM IDLE: an instruction with id_ex_valid=1 and aluop=MUL, with mem_stall=0, latches opA and opB into the multiplier, sets count=0 and goes to RUN. stall_out=1 in that same cycle.
- Operands are latched at the start because the forwarding sources drain while the pipe stalls.
- FSM RUN: one shift-add step per cycle. stall_out=1. EX/MEM loads bubbles unless mem_stall. When count==MUL_ITERS-1, go to DONE.
- FSM DONE: stall_out=mem_stall. On the first edge with mem_stall=0, EX/MEM loads the product with the held ID/EX control, and the FSM returns to IDLE.
- MUL timing: stall_out is high for 33 cycles, and the result appears in EX/MEM after the 34th edge.
- A MUL with id_ex_valid=0 does not start the FSM.
- Reset or flush in the middle of a multiply abandons it; nothing is written.
- Forwarding validity (for example load-use) is the hazard unit's responsibility. This block muxes exactly as told.

Decomposition:
- Package pipe_pkg holds: ALU opcode constants, FWD_IDEX/FWD_EXMEM/FWD_MEMWB codes, the mul FSM state enum (IDLE/RUN/DONE), and XLEN.
- One sub-module, mul_iter: operand latch, shift-add datapath and counter, with start/busy/done signals. The FSM and pipeline register stay in ex_stage.

Test Plan:
- ADD, forward_a=10, forward_b=01, ex_mem_alu_result=5, mem_wb_write_data=7 -> next edge ex_mem_alu_result=12, ex_mem_valid=1.
- SLT, opA=0xFFFFFFFF, opB=1 -> result 1. Same operands with SLTU -> result 0. SRA of 0x80000000 by 4 -> 0xF8000000.
- MUL 0x12345678*0x10, with the forward sources changed after the start cycle -> stall_out high for exactly 33 cycles, then the result is 0x23456780 and the changed sources are ignored.
- mem_stall held for 3 cycles during a single-cycle op -> EX/MEM unchanged and stall_out=1 for those cycles; the op loads on release.
- flush asserted at RUN cycle 10 of a MUL -> EX/MEM gets a bubble, the FSM goes to IDLE, stall_out=0 next cycle, and there is no later writeback.
- rst_n dropped asynchronously mid-MUL -> all outputs are 0 immediately without a clock edge; after release, the next ADD completes in 1 cycle.
